// File: rtl/huffman_pkg.sv
`default_nettype none
// ============================================================================
// huffman_pkg : shared sizes, FSM encoding and symbol helpers for the
//               4-symbol Huffman code generator.          Rev 1.0
// ============================================================================
package huffman_pkg;

  localparam int NSYM   = 4;
  localparam int LEN_W  = 2;
  localparam int CODE_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FIND  = 3'd2,
    ST_MERGE = 3'd3,
    ST_CANON = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Slot i carries symbol 4'hA + i.
  function automatic logic [3:0] sym_nibble(input logic [1:0] idx);
    return 4'hA + {2'b00, idx};
  endfunction

endpackage : huffman_pkg
`default_nettype wire

// File: rtl/huffman_canon_coder.sv
`default_nettype none
// ============================================================================
// huffman_canon_coder : canonical code assignment from per-symbol lengths,
//                       one (length, symbol) pair per cycle, 12 cycles. Rev 1.0
// ============================================================================
module huffman_canon_coder
  import huffman_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [NSYM-1:0][LEN_W-1:0]   len_i,
  output logic                         done_o,
  output logic [NSYM-1:0][CODE_W-1:0]  codes_o
);

  localparam logic [3:0] LAST_IDX = 4'd11;

  logic                        busy_q,  busy_d;
  logic [3:0]                  idx_q,   idx_d;
  logic [CODE_W:0]             code_q,  code_d;
  logic [NSYM-1:0][CODE_W-1:0] codes_q, codes_d;
  logic [1:0]                  w_sym;
  logic [LEN_W-1:0]            w_level;

  assign w_sym   = idx_q[1:0];
  assign w_level = idx_q[3:2] + 2'd1;

  always_comb begin
    busy_d  = busy_q;
    idx_d   = idx_q;
    code_d  = code_q;
    codes_d = codes_q;
    if (start_i) begin
      busy_d  = 1'b1;
      idx_d   = '0;
      code_d  = '0;
      codes_d = '0;
    end else if (busy_q) begin
      if (len_i[w_sym] == w_level) begin
        codes_d[w_sym] = code_q[CODE_W-1:0];
        code_d         = code_q + 1'b1;
      end
      if (w_sym == 2'(NSYM-1)) begin
        code_d = code_d << 1;
      end
      idx_d = idx_q + 4'd1;
      if (idx_q == LAST_IDX) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= 1'b0;
      idx_q   <= '0;
      code_q  <= '0;
      codes_q <= '0;
    end else begin
      busy_q  <= busy_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      codes_q <= codes_d;
    end
  end

  // done_o marks the cycle of the last pair; codes_o already includes that pair.
  assign done_o  = busy_q && (idx_q == LAST_IDX);
  assign codes_o = codes_d;

endmodule : huffman_canon_coder
`default_nettype wire

// File: rtl/huffman_code_gen.sv
`default_nettype none
// ============================================================================
// huffman_code_gen : builds a 4-leaf Huffman tree by two-minimum merging and
//                    emits canonical codes. Option macro: HUFF_KRAFT_CHECK_EN
//                    (adds KRAFT_ERR output).                       Rev 1.0
// ============================================================================
module huffman_code_gen
  import huffman_pkg::*;
#(
  parameter int FREQ_W = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       START,
  input  logic [NSYM*FREQ_W-1:0]     FREQUENT_IN,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [NSYM*LEN_W-1:0]      CODE_LEN_OUT,
  output logic [NSYM*CODE_W-1:0]     CODE_OUT
`ifdef HUFF_KRAFT_CHECK_EN
  ,
  output logic                       KRAFT_ERR
`endif
);

  localparam int WW = FREQ_W + 2;

  state_t                      state_q,    state_d;
  logic [NSYM-1:0][WW-1:0]     weight_q,   weight_d;
  logic [NSYM-1:0][NSYM-1:0]   mask_q,     mask_d;
  logic [NSYM-1:0]             active_q,   active_d;
  logic [NSYM-1:0][LEN_W-1:0]  len_q,      len_d;
  logic [1:0]                  scan_q,     scan_d;
  logic [1:0]                  merges_q,   merges_d;
  logic [1:0]                  m1_idx_q,   m1_idx_d;
  logic [1:0]                  m2_idx_q,   m2_idx_d;
  logic                        m1_v_q,     m1_v_d;
  logic                        m2_v_q,     m2_v_d;
  logic [NSYM*LEN_W-1:0]       len_out_q,  len_out_d;
  logic [NSYM*CODE_W-1:0]      code_out_q, code_out_d;

  logic                        w_canon_start;
  logic                        w_canon_done;
  logic [NSYM-1:0][CODE_W-1:0] w_canon_codes;
  logic [NSYM-1:0]             w_pair_mask;
  logic [1:0]                  w_lo, w_hi;
  logic [2:0]                  w_nz_cnt;

  assign w_pair_mask = mask_q[m1_idx_q] | mask_q[m2_idx_q];
  assign w_lo        = (m1_idx_q < m2_idx_q) ? m1_idx_q : m2_idx_q;
  assign w_hi        = (m1_idx_q < m2_idx_q) ? m2_idx_q : m1_idx_q;

  always_comb begin
    w_nz_cnt = '0;
    for (int i = 0; i < NSYM; i++) begin
      w_nz_cnt = w_nz_cnt + 3'(active_q[i]);
    end
  end

  always_comb begin
    state_d       = state_q;
    weight_d      = weight_q;
    mask_d        = mask_q;
    active_d      = active_q;
    len_d         = len_q;
    scan_d        = scan_q;
    merges_d      = merges_q;
    m1_idx_d      = m1_idx_q;
    m2_idx_d      = m2_idx_q;
    m1_v_d        = m1_v_q;
    m2_v_d        = m2_v_q;
    len_out_d     = len_out_q;
    code_out_d    = code_out_q;
    w_canon_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          for (int i = 0; i < NSYM; i++) begin
            weight_d[i]    = {2'b00, FREQUENT_IN[i*FREQ_W +: FREQ_W]};
            mask_d[i]      = '0;
            mask_d[i][i]   = 1'b1;
            active_d[i]    = |FREQUENT_IN[i*FREQ_W +: FREQ_W];
            len_d[i]       = '0;
          end
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        scan_d = '0;
        m1_v_d = 1'b0;
        m2_v_d = 1'b0;
        if (w_nz_cnt >= 3'd2) begin
          merges_d = 2'(w_nz_cnt - 3'd1);
          state_d  = ST_FIND;
        end else begin
          // A lone symbol still needs a 1-bit code; an empty alphabet keeps 0.
          for (int i = 0; i < NSYM; i++) begin
            if (active_q[i]) len_d[i] = 2'd1;
          end
          w_canon_start = 1'b1;
          state_d       = ST_CANON;
        end
      end
      ST_FIND: begin
        // Strict compares with an ascending scan keep ties on the lower slot.
        if (active_q[scan_q]) begin
          if (!m1_v_q || (weight_q[scan_q] < weight_q[m1_idx_q])) begin
            m2_idx_d = m1_idx_q;
            m2_v_d   = m1_v_q;
            m1_idx_d = scan_q;
            m1_v_d   = 1'b1;
          end else if (!m2_v_q || (weight_q[scan_q] < weight_q[m2_idx_q])) begin
            m2_idx_d = scan_q;
            m2_v_d   = 1'b1;
          end
        end
        scan_d = scan_q + 2'd1;
        if (scan_q == 2'(NSYM-1)) state_d = ST_MERGE;
      end
      ST_MERGE: begin
        weight_d[w_lo] = weight_q[m1_idx_q] + weight_q[m2_idx_q];
        mask_d[w_lo]   = w_pair_mask;
        weight_d[w_hi] = '0;
        mask_d[w_hi]   = '0;
        active_d[w_hi] = 1'b0;
        for (int i = 0; i < NSYM; i++) begin
          if (w_pair_mask[i]) len_d[i] = len_q[i] + 2'd1;
        end
        merges_d = merges_q - 2'd1;
        scan_d   = '0;
        m1_v_d   = 1'b0;
        m2_v_d   = 1'b0;
        if (merges_q == 2'd1) begin
          w_canon_start = 1'b1;
          state_d       = ST_CANON;
        end else begin
          state_d = ST_FIND;
        end
      end
      ST_CANON: begin
        if (w_canon_done) begin
          len_out_d  = len_q;
          code_out_d = w_canon_codes;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ST_IDLE;
      weight_q   <= '0;
      mask_q     <= '0;
      active_q   <= '0;
      len_q      <= '0;
      scan_q     <= '0;
      merges_q   <= '0;
      m1_idx_q   <= '0;
      m2_idx_q   <= '0;
      m1_v_q     <= 1'b0;
      m2_v_q     <= 1'b0;
      len_out_q  <= '0;
      code_out_q <= '0;
    end else begin
      state_q    <= state_d;
      weight_q   <= weight_d;
      mask_q     <= mask_d;
      active_q   <= active_d;
      len_q      <= len_d;
      scan_q     <= scan_d;
      merges_q   <= merges_d;
      m1_idx_q   <= m1_idx_d;
      m2_idx_q   <= m2_idx_d;
      m1_v_q     <= m1_v_d;
      m2_v_q     <= m2_v_d;
      len_out_q  <= len_out_d;
      code_out_q <= code_out_d;
    end
  end

  huffman_canon_coder u_canon (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .start_i (w_canon_start),
    .len_i   (len_q),
    .done_o  (w_canon_done),
    .codes_o (w_canon_codes)
  );

`ifdef HUFF_KRAFT_CHECK_EN
  logic       kraft_q, kraft_d;
  logic [4:0] w_kraft_sum;
  logic [2:0] w_used;

  // A complete prefix code over depth 3 fills exactly 8 leaf slots.
  always_comb begin
    w_kraft_sum = '0;
    w_used      = '0;
    for (int i = 0; i < NSYM; i++) begin
      if (len_q[i] != '0) begin
        w_kraft_sum = w_kraft_sum + 5'(4'd8 >> len_q[i]);
        w_used      = w_used + 3'd1;
      end
    end
    kraft_d = kraft_q;
    if ((state_q == ST_CANON) && w_canon_done) begin
      kraft_d = (w_used >= 3'd2) && (w_kraft_sum != 5'd8);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) kraft_q <= 1'b0;
    else       kraft_q <= kraft_d;
  end

  assign KRAFT_ERR = kraft_q;
`endif

  assign BUSY         = (state_q != ST_IDLE);
  assign DONE         = (state_q == ST_DONE);
  assign CODE_LEN_OUT = len_out_q;
  assign CODE_OUT     = code_out_q;

endmodule : huffman_code_gen
`default_nettype wire

// File: tb/tb_huffman_code_gen.sv
`default_nettype none
// ============================================================================
// tb_huffman_code_gen : directed self-checking bench for huffman_code_gen.
//                                                                   Rev 1.0
// ============================================================================
module tb_huffman_code_gen;

  logic        CLK;
  logic        nRST;
  logic        START;
  logic [15:0] FREQUENT_IN;
  logic        BUSY;
  logic        DONE;
  logic [7:0]  CODE_LEN_OUT;
  logic [11:0] CODE_OUT;
`ifdef HUFF_KRAFT_CHECK_EN
  logic        KRAFT_ERR;
`endif

  int errors = 0;
  int checks = 0;

  huffman_code_gen #(.FREQ_W(4)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .START        (START),
    .FREQUENT_IN  (FREQUENT_IN),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .CODE_LEN_OUT (CODE_LEN_OUT),
    .CODE_OUT     (CODE_OUT)
`ifdef HUFF_KRAFT_CHECK_EN
    ,
    .KRAFT_ERR    (KRAFT_ERR)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launches a job, optionally injects a second START at +5, and checks the result.
  task automatic run_job(input string name, input logic [15:0] freq,
                         input logic [7:0] exp_len, input logic [11:0] exp_code,
                         input int exp_lat, input logic poke);
    int cnt;
    @(negedge CLK);
    FREQUENT_IN = freq;
    START       = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    cnt   = 0;
    while (!DONE && cnt < 60) begin
      @(posedge CLK);
      #1;
      cnt++;
      if (poke && cnt == 5) begin
        FREQUENT_IN = 16'h1111;
        START       = 1'b1;
        @(posedge CLK);
        #1;
        cnt++;
        START = 1'b0;
      end
    end
    check({name, "_latency"}, 32'(cnt), 32'(exp_lat));
    check({name, "_len"}, 32'(CODE_LEN_OUT), 32'(exp_len));
    check({name, "_code"}, 32'(CODE_OUT), 32'(exp_code));
    check({name, "_busy_at_done"}, 32'(BUSY), 32'd1);
`ifdef HUFF_KRAFT_CHECK_EN
    check({name, "_kraft"}, 32'(KRAFT_ERR), 32'd0);
`endif
    @(posedge CLK);
    #1;
    check({name, "_done_pulse"}, 32'(DONE), 32'd0);
    check({name, "_busy_after"}, 32'(BUSY), 32'd0);
    check({name, "_len_held"}, 32'(CODE_LEN_OUT), 32'(exp_len));
  endtask

  initial begin
    int seen_done;
    nRST        = 1'b0;
    START       = 1'b0;
    FREQUENT_IN = 16'h0000;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_len", 32'(CODE_LEN_OUT), 32'd0);
    check("rst_code", 32'(CODE_OUT), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    run_job("mixed", 16'h3121, 8'h7B, 12'h1D6, 28, 1'b0);
    run_job("equal", 16'h1111, 8'hAA, 12'h688, 28, 1'b0);
    run_job("c_only", 16'h0500, 8'h10, 12'h000, 13, 1'b0);
    run_job("all_zero", 16'h0000, 8'h00, 12'h000, 13, 1'b0);
    // Second START mid-job must be dropped, not queued.
    run_job("ignored", 16'h3121, 8'h7B, 12'h1D6, 28, 1'b1);
    repeat (3) @(posedge CLK);
    #1;
    check("no_queue_busy", 32'(BUSY), 32'd0);

    // Abort a running job with reset at +10.
    @(negedge CLK);
    FREQUENT_IN = 16'h1111;
    START       = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    check("pre_abort_busy", 32'(BUSY), 32'd1);
    nRST = 1'b0;
    #1;
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_len", 32'(CODE_LEN_OUT), 32'd0);
    check("abort_code", 32'(CODE_OUT), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    seen_done = 0;
    repeat (30) begin
      @(posedge CLK);
      #1;
      if (DONE) seen_done = 1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    check("abort_idle", 32'(BUSY), 32'd0);

    run_job("post_abort", 16'h0500, 8'h10, 12'h000, 13, 1'b0);
    run_job("post_abort2", 16'h3121, 8'h7B, 12'h1D6, 28, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_huffman_code_gen
`default_nettype wire
